uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
Single-clock system controller between the UART receive path and the register file, ALU and TX FIFO. It parses command frames from received bytes and drives register-file writes and reads and ALU operations. It returns results as bytes into the TX FIFO for the UART transmitter. It is the only agent that sequences these resources.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX/register-file data
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
TIMEOUT, 255, max cycles waited for RF_RD_DATA_VLD or ALU_OUT_VLD (8-bit counter)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte, already synchronized to CLK
RX_D_VLD  in  1  one-cycle pulse per received byte
RF_RD_DATA  in  DATA_WIDTH  register-file read data
RF_RD_DATA_VLD  in  1  read data valid pulse
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
FIFO_FULL  in  1  TX FIFO full
RF_ADDRESS  out  ADDR_WIDTH  register-file address
RF_WR_EN  out  1  write strobe
RF_RD_EN  out  1  read strobe
RF_WR_DATA  out  DATA_WIDTH  write data
ALU_EN  out  1  ALU start strobe
ALU_FUN  out  FUN_WIDTH  ALU function
CLK_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte pushed to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- All outputs registered. Reset (RST=0, async) sets all outputs to 0 and the FSM to IDLE; the timeout counter and result registers clear.
- Command bytes: 0xAA = RF write (addr, data). 0xBB = RF read (addr). 0xCC = ALU with operands (A, B, fun). 0xDD = ALU without operands (fun).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB.
- IDLE, on a byte:
  - 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> ALU_FUN.
  - Any other value: CMD_ERR pulses the next cycle; stay IDLE.
- Byte-accepting states act only on RX_D_VLD. Any strobe is high for exactly the one cycle after the accepting edge.
  - WR_ADDR: latch addr -> WR_DATA.
  - WR_DATA: RF_WR_EN=1, RF_ADDRESS=addr, RF_WR_DATA=byte -> IDLE. No response byte is sent.
  - RD_ADDR: RF_RD_EN=1, RF_ADDRESS=byte -> RD_WAIT.
  - OP_A: RF_WR_EN to address 0 with the byte -> OP_B.
  - OP_B: RF_WR_EN to address 1 with the byte -> ALU_FUN.
  - ALU_FUN: ALU_EN=1, ALU_FUN=byte[FUN_WIDTH-1:0], CLK_EN=1 -> ALU_WAIT.
- CLK_EN rises in the same cycle as ALU_EN. It stays high until the cycle after the ALU result is captured or the ALU wait times out, then drops to 0.
- RD_WAIT: on RF_RD_DATA_VLD, capture RF_RD_DATA -> TX_LSB (single-byte response; the read result goes in the LSB slot).
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT -> TX_LSB (two-byte response).
- Timeout counter:
  - Clears on entry to RD_WAIT/ALU_WAIT and increments each wait cycle.
  - On reaching TIMEOUT: CMD_ERR pulse, CLK_EN=0, -> IDLE.
  - A valid pulse arriving in the same cycle as the timeout wins: the result is captured and there is no error.
- TX_LSB: when FIFO_FULL=0, TX_D_VLD=1 with the low byte. Then -> TX_MSB for ALU commands, or IDLE for RF reads. While FIFO_FULL=1, hold with no strobe and no limit.
- TX_MSB: same rule with the high byte -> IDLE.
- RX bytes arriving in RD_WAIT, ALU_WAIT, TX_LSB or TX_MSB are dropped silently. They are not queued and do not trigger CMD_ERR.
- A byte arriving in the same cycle the FSM returns to IDLE is treated as arriving in the prior state.
- Latency: strobe 1 cycle after the last command byte; first TX_D_VLD 1 cycle after the valid pulse when the FIFO is not full.
- Reset mid-command aborts immediately. Partial commands are discarded and no strobe is emitted.

Test Plan:
- Bytes 0xAA,0x05,0x3C -> one RF_WR_EN pulse with RF_ADDRESS=5, RF_WR_DATA=0x3C; no TX_D_VLD.
- 0xBB,0x05, RF_RD_DATA=0x3C with VLD 2 cycles later -> RF_RD_EN pulse with addr 5; TX_D_VLD once with 0x3C; back to IDLE.
- 0xCC,0x12,0x34,0x01, ALU_OUT=0x0046 with VLD -> writes to addr 0=0x12 and addr 1=0x34; ALU_EN with ALU_FUN=1 and CLK_EN high until capture; TX bytes 0x46 then 0x00.
- 0xDD,0x02 with FIFO_FULL=1 for 10 cycles after the result -> no TX_D_VLD while full; both bytes are sent in order after FIFO_FULL drops.
- Byte 0x7E in IDLE -> CMD_ERR pulse, no other strobe; 0xBB,0x03 with no RF_RD_DATA_VLD -> CMD_ERR after TIMEOUT=255 cycles, then IDLE.
- RST low during OP_B -> all outputs 0 asynchronously; a subsequent 0xAA,0x01,0xFF executes normally.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses RX command frames, sequences the register
// file and ALU, and streams results back into the TX FIFO.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   RF_ADDRESS,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    CMD_ERR
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OP_A,
    S_OP_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_LSB,
    S_TX_MSB
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'(8'hDD);
  localparam logic [7:0]            TO_LAST = 8'(TIMEOUT - 1);

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    alu_q, alu_d;
  logic [7:0]              cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]   rf_address_d;
  logic                    rf_wr_en_d;
  logic                    rf_rd_en_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d;
  logic                    alu_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;
  logic                    clk_en_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_d;
  logic                    tx_d_vld_d;
  logic                    cmd_err_d;

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    res_d        = res_q;
    alu_d        = alu_q;
    cnt_d        = '0;
    rf_address_d = RF_ADDRESS;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_wr_data_d = RF_WR_DATA;
    alu_en_d     = 1'b0;
    alu_fun_d    = ALU_FUN;
    clk_en_d     = CLK_EN;
    tx_p_data_d  = TX_P_DATA;
    tx_d_vld_d   = 1'b0;
    cmd_err_d    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:  state_d = S_WR_ADDR;
            CMD_RD:  state_d = S_RD_ADDR;
            CMD_OP:  state_d = S_OP_A;
            CMD_NOP: state_d = S_ALU_FUN;
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_address_d = addr_q;
          rf_wr_data_d = RX_P_DATA;
          state_d      = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_rd_en_d   = 1'b1;
          rf_address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          alu_d        = 1'b0;
          state_d      = S_RD_WAIT;
        end
      end
      S_OP_A: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_address_d = '0;
          rf_wr_data_d = RX_P_DATA;
          state_d      = S_OP_B;
        end
      end
      S_OP_B: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_address_d = ADDR_WIDTH'(1);
          rf_wr_data_d = RX_P_DATA;
          state_d      = S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          clk_en_d  = 1'b1;
          alu_d     = 1'b1;
          state_d   = S_ALU_WAIT;
        end
      end
      S_RD_WAIT: begin
        // the LSB goes out on the capture edge itself when the FIFO has room
        if (RF_RD_DATA_VLD) begin
          res_d = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
          if (!FIFO_FULL) begin
            tx_d_vld_d  = 1'b1;
            tx_p_data_d = RF_RD_DATA;
            state_d     = S_IDLE;
          end else begin
            state_d = S_TX_LSB;
          end
        end else if (cnt_q == TO_LAST) begin
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_d    = ALU_OUT;
          clk_en_d = 1'b0;
          if (!FIFO_FULL) begin
            tx_d_vld_d  = 1'b1;
            tx_p_data_d = ALU_OUT[DATA_WIDTH-1:0];
            state_d     = S_TX_MSB;
          end else begin
            state_d = S_TX_LSB;
          end
        end else if (cnt_q == TO_LAST) begin
          cmd_err_d = 1'b1;
          clk_en_d  = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TX_LSB: begin
        if (!FIFO_FULL) begin
          tx_d_vld_d  = 1'b1;
          tx_p_data_d = res_q[DATA_WIDTH-1:0];
          state_d     = alu_q ? S_TX_MSB : S_IDLE;
        end
      end
      S_TX_MSB: begin
        if (!FIFO_FULL) begin
          tx_d_vld_d  = 1'b1;
          tx_p_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      res_q      <= '0;
      alu_q      <= 1'b0;
      cnt_q      <= '0;
      RF_ADDRESS <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLK_EN     <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      res_q      <= res_d;
      alu_q      <= alu_d;
      cnt_q      <= cnt_d;
      RF_ADDRESS <= rf_address_d;
      RF_WR_EN   <= rf_wr_en_d;
      RF_RD_EN   <= rf_rd_en_d;
      RF_WR_DATA <= rf_wr_data_d;
      ALU_EN     <= alu_en_d;
      ALU_FUN    <= alu_fun_d;
      CLK_EN     <= clk_en_d;
      TX_P_DATA  <= tx_p_data_d;
      TX_D_VLD   <= tx_d_vld_d;
      CMD_ERR    <= cmd_err_d;
    end
  end

endmodule
